// File: rtl/data_cache.sv
// rtl/data_cache.sv - set-associative write-through, no-write-allocate data cache
// hit doubles as the global pipeline advance signal; requests must be held while it is low.
module data_cache #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int SETS       = 16,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              hit,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [31:0]       rd_hits,
   output logic [31:0]       rd_misses
);
   localparam int OFF_BITS = $clog2(LINE_WORDS);
   localparam int IDX_BITS = $clog2(SETS);
   localparam int WA_W     = ADDR_W - 2;
   localparam int TAG_W    = WA_W - OFF_BITS - IDX_BITS;
   localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
   localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} stateT;

   stateT state, nextState;

   logic                validArr [WAYS][SETS];
   logic [TAG_W-1:0]    tagArr   [WAYS][SETS];
   logic [DATA_W-1:0]   dataArr  [WAYS][SETS][LINE_WORDS];
   logic [WAY_W-1:0]    rrPtr    [SETS];

   logic [WA_W-1:0]     wordAddr;
   logic [WA_W-1:0]     fillWordAddr;
   logic [OFF_W-1:0]    wordOff;
   logic [IDX_BITS-1:0] setIdx;
   logic [TAG_W-1:0]    tagBits;
   logic [1:0]          unusedByteBits;
   logic [OFF_W-1:0]    wordCnt;
   logic [WAY_W-1:0]    victimWay;
   logic [WAY_W-1:0]    victimSel;
   logic [WAY_W-1:0]    hitWay;
   logic                lookupHit;
   logic                isRead;
   logic                isWrite;
   logic                lastWord;

   assign wordAddr       = cpu_addr[ADDR_W-1:2];
   assign unusedByteBits = cpu_addr[1:0];
   assign wordOff        = OFF_W'(wordAddr & WA_W'(LINE_WORDS - 1));
   assign setIdx         = IDX_BITS'(wordAddr >> OFF_BITS);
   assign tagBits        = TAG_W'(wordAddr >> (OFF_BITS + IDX_BITS));
   assign fillWordAddr   = (wordAddr & ~WA_W'(LINE_WORDS - 1)) | WA_W'(wordCnt);
   assign isWrite        = cpu_write;
   assign isRead         = cpu_read && !cpu_write;
   assign lastWord       = (wordCnt == OFF_W'(LINE_WORDS - 1));

   // Tags within a set are unique, so at most one way can match.
   always_comb begin
      lookupHit = 1'b0;
      hitWay    = '0;
      victimSel = rrPtr[setIdx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (validArr[w][setIdx] && tagArr[w][setIdx] == tagBits) begin
            lookupHit = 1'b1;
            hitWay    = WAY_W'(w);
         end
         if (!validArr[w][setIdx]) victimSel = WAY_W'(w);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      hit       = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      case (state)
         IDLE: begin
            if (isWrite) begin
               nextState = WRITE;
            end else if (isRead && !lookupHit) begin
               nextState = FILL;
            end else begin
               hit = 1'b1;
               if (isRead) cpu_rdata = dataArr[hitWay][setIdx][wordOff];
            end
         end
         FILL: begin
            mem_read = 1'b1;
            mem_addr = {fillWordAddr, 2'b00};
            if (mem_ack && lastWord) nextState = IDLE;
         end
         WRITE: begin
            mem_write = 1'b1;
            mem_addr  = {wordAddr, 2'b00};
            mem_wdata = cpu_wdata;
            if (mem_ack) nextState = WDONE;
         end
         WDONE: begin
            hit       = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wordCnt   <= '0;
         victimWay <= '0;
         rd_hits   <= '0;
         rd_misses <= '0;
         for (int s = 0; s < SETS; s++) begin
            rrPtr[s] <= '0;
            for (int w = 0; w < WAYS; w++) validArr[w][s] <= 1'b0;
         end
      end else begin
         if (state == IDLE && isRead) begin
            if (lookupHit) begin
               rd_hits <= rd_hits + 32'd1;
            end else begin
               rd_misses <= rd_misses + 32'd1;
               wordCnt   <= '0;
               victimWay <= victimSel;
            end
         end
         if (state == FILL && mem_ack) begin
            wordCnt <= wordCnt + 1'b1;
            if (lastWord) begin
               validArr[victimWay][setIdx] <= 1'b1;
               rrPtr[setIdx] <= (rrPtr[setIdx] == WAY_W'(WAYS - 1)) ? '0 : rrPtr[setIdx] + 1'b1;
            end
         end
      end
   end

   // Line payload carries no reset; validity alone guards its use.
   always_ff @(posedge clk) begin
      if (state == FILL && mem_ack) begin
         dataArr[victimWay][setIdx][wordCnt] <= mem_rdata;
         if (lastWord) tagArr[victimWay][setIdx] <= tagBits;
      end
      if (state == WRITE && mem_ack && lookupHit)
         dataArr[hitWay][setIdx][wordOff] <= cpu_wdata;
   end
endmodule

// File: doc/data_cache.md
# data_cache

Parametrised set-associative, write-through, no-write-allocate data cache placed between the pipeline MEM stage and the backing data memory. Its `hit` output is the global pipeline advance signal: the IF/ID, ID/EX, EX/MEM and MEM/WB registers hold while `hit` is 0. The block generalises the single direct-mapped line store to configurable sets, ways and line size, with round-robin replacement and read hit/miss counters.

## Interface
Parameters:
- `DATA_W`, 32, data word width; byte address granularity is 4 bytes per word, so the low 2 address bits are ignored.
- `ADDR_W`, 32, CPU/memory byte address width.
- `SETS`, 16, number of sets; power of 2, ≥ 2.
- `WAYS`, 2, associativity; one of 1, 2 or 4.
- `LINE_WORDS`, 4, words per line; power of 2, ≥ 1.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_read` in 1: MEM-stage load request.
- `cpu_write` in 1: MEM-stage store request.
- `cpu_addr` in ADDR_W: byte address.
- `cpu_wdata` in DATA_W: store data.
- `cpu_rdata` out DATA_W: load data, valid when `hit`=1 and `cpu_read`=1.
- `hit` out 1: 1 means the pipeline advances at this edge; 0 means stall.
- `mem_read` out 1: backing read request.
- `mem_write` out 1: backing write request.
- `mem_addr` out ADDR_W: backing word address, byte form, low 2 bits 0.
- `mem_wdata` out DATA_W: backing write data.
- `mem_rdata` in DATA_W: backing read data, sampled when `mem_ack`=1.
- `mem_ack` in 1: backing memory completes the current request this cycle.
- `rd_hits` out 32: count of load hits, wraps modulo 2^32.
- `rd_misses` out 32: count of load misses, wraps modulo 2^32.

## Operation
- Address split, LSB first: 2 byte bits, log2(LINE_WORDS) offset bits, log2(SETS) index bits, remaining bits tag.
- Per way/set storage: valid bit, tag, LINE_WORDS data words. Per set: a round-robin pointer of log2(WAYS) bits.
- States:
  - IDLE: the tag lookup is combinational.
    - No request: `hit`=1.
    - Read hit: `hit`=1, `cpu_rdata`=matching word, `rd_hits`+1.
    - Read miss: `hit`=0, `rd_misses`+1, go to FILL with word counter 0.
    - Write: `hit`=0, go to WRITE.
  - FILL: `mem_read`=1 and `mem_addr`=line base + 4·counter, held stable until `mem_ack`.
    - On each ack, store `mem_rdata` in the victim way and increment the counter.
    - On the ack for word LINE_WORDS-1: set valid, write the tag, advance the set pointer, go to IDLE.
  - WRITE: `mem_write`=1, `mem_addr`=`cpu_addr` with low 2 bits cleared, `mem_wdata`=`cpu_wdata`, all held stable until `mem_ack`.
    - On ack: if the line is present, update the cached word; go to WDONE.
    - On a miss, no line is allocated.
  - WDONE: `hit`=1 for exactly one cycle, then go to IDLE.
- Victim selection: the lowest-numbered invalid way; if all ways are valid, the way given by the set's round-robin pointer. The pointer increments modulo WAYS only when a fill completes.
- After FILL, the returning IDLE cycle re-looks up the held request, hits, and counts as a hit. Each miss therefore also produces one `rd_hits` increment.
- `cpu_read` and `cpu_write` both high: treated as a write. `cpu_read` is ignored.
- Request inputs are sampled only in IDLE. They must be held by the stalled pipeline while `hit`=0.

## Timing
- Reset values:
  - State IDLE, all valid bits 0, all pointers 0, counters 0.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `rd_hits`=0, `rd_misses`=0.
  - `hit`=1; `cpu_rdata`=0 while no hit.
- Reset mid-FILL or mid-WRITE: the request drops immediately. A partially filled line is never marked valid.
- Read hit: 0-cycle latency; `hit` and `cpu_rdata` are valid in the request cycle.
- Read miss with `mem_ack` high on every first request cycle: `hit`=0 for LINE_WORDS+1 cycles, then `hit`=1. With defaults, that is 5 stall cycles.
- Write with immediate ack: `hit`=0 for 2 cycles (IDLE, WRITE), then `hit`=1 in WDONE.
- `mem_ack` outside FILL/WRITE is ignored.

## Test plan
- Reset, then read 0x100: `rd_misses`=1; `mem_read` at 0x100, 0x104, 0x108, 0x10C in order; `hit` rises in cycle 5; `cpu_rdata` = memory[0x100]; `rd_hits`=1.
- Read 0x10C immediately after: `hit`=1 in the same cycle, no `mem_read`, `rd_hits`=2.
- Write 0xDEADBEEF to 0x104 (line present): one `mem_write` at 0x104; `hit`=1 in WDONE; a subsequent read of 0x104 hits with 0xDEADBEEF. A write to the uncached 0x800 produces no fill.
- Three lines mapping to set 0 (0x000, 0x100, 0x200 with defaults): the third fill evicts way 0. Re-reading 0x000 misses and 0x100 hits.
- Assert `rst` during the 3rd FILL word: `mem_read` falls asynchronously. A later read of the same address misses and refills all 4 words.
- `mem_ack` delayed 3 cycles per word: `mem_addr` stays stable throughout and `hit` stays 0 until the fill completes.
